// File: rtl/slow_clock_monitor_if.sv
// Signal bundle between a slow square-wave source and its clock_in-domain monitor.
// The monitor side is the slave modport; the source/consumer side is the master.
interface slow_clock_monitor_if #(
    parameter int CNT_W = 28
);
    logic             slow_in;
    logic             tick;
    logic             fall_tick;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output slow_in,
        input  tick, fall_tick, period, high_time, period_valid, locked, timeout
    );

    modport slave (
        input  slow_in,
        output tick, fall_tick, period, high_time, period_valid, locked, timeout
    );
endinterface

// File: rtl/slow_clock_monitor.sv
// Synchronises a slow square wave into clock_in, emits rise/fall enable ticks,
// measures period and high time, and tracks frequency lock and loss of signal.
module slow_clock_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 28,
    parameter int TIMEOUT     = 100_000_000,
    parameter int LOCK_COUNT  = 4,
    parameter int TOLERANCE   = 2
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    slow_clock_monitor_if.slave  mon
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]     TOL_C     = (CNT_W + 1)'(TOLERANCE);
    localparam logic [MATCH_W-1:0] LOCK_C    = MATCH_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]   ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   MAX_C     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q,         sync_d;
    logic [SYNC_STAGES:0]   fill_q,         fill_d;
    logic                   s_d_q,          s_d_d;
    logic [CNT_W-1:0]       cnt_q,          cnt_d;
    logic [CNT_W-1:0]       hcnt_q,         hcnt_d;
    logic [CNT_W-1:0]       period_q,       period_d;
    logic [CNT_W-1:0]       high_time_q,    high_time_d;
    logic [MATCH_W-1:0]     match_q,        match_d;
    logic                   period_valid_q, period_valid_d;
    logic                   locked_q,       locked_d;
    logic                   tick_q,         tick_d;
    logic                   fall_tick_q,    fall_tick_d;
    logic                   timeout_q,      timeout_d;
    state_t                 state_q,        state_d;

    logic                   s_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   expire_s;
    logic                   lose_s;
    logic                   in_tol_s;
    logic [CNT_W:0]         cnt_ext_s;
    logic [CNT_W:0]         per_ext_s;
    logic [CNT_W:0]         diff_s;
    logic [MATCH_W-1:0]     match_inc_s;

    // Next-state logic: edge detection, counters and the lock/timeout state machine.
    always_comb begin
        s_s    = sync_q[SYNC_STAGES-1];
        sync_d = {sync_q[SYNC_STAGES-2:0], mon.slow_in};
        s_d_d  = s_s;
        // Edges count only once the chain and edge flop hold real samples, so an
        // input already high when reset releases is not mistaken for a rise.
        fill_d = {fill_q[SYNC_STAGES-1:0], 1'b1};
        rise_s = fill_q[SYNC_STAGES] &  s_s & ~s_d_q;
        fall_s = fill_q[SYNC_STAGES] & ~s_s &  s_d_q;

        cnt_ext_s = {1'b0, cnt_q};
        per_ext_s = {1'b0, period_q};
        if (cnt_ext_s >= per_ext_s) begin
            diff_s = cnt_ext_s - per_ext_s;
        end else begin
            diff_s = per_ext_s - cnt_ext_s;
        end
        in_tol_s    = (diff_s <= TOL_C);
        match_inc_s = match_q + MATCH_W'(1);
        expire_s    = (state_q != ST_IDLE) && (cnt_q == TIMEOUT_C) && !rise_s;

        tick_d         = rise_s;
        fall_tick_d    = fall_s;
        timeout_d      = 1'b0;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        locked_d       = locked_q;
        match_d        = match_q;
        state_d        = state_q;
        lose_s         = 1'b0;

        if (rise_s) begin
            cnt_d = ONE_C;
        end else if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == TIMEOUT_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + ONE_C;
        end

        if (rise_s) begin
            hcnt_d = ONE_C;
        end else if (s_s && (hcnt_q != MAX_C)) begin
            hcnt_d = hcnt_q + ONE_C;
        end else begin
            hcnt_d = hcnt_q;
        end

        if (fall_s && (state_q != ST_IDLE)) begin
            high_time_d = hcnt_q;
        end else begin
            high_time_d = high_time_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (rise_s) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    match_d        = '0;
                    state_d        = ST_TRACK;
                end else begin
                    lose_s = expire_s;
                end
            end
            ST_TRACK: begin
                if (rise_s) begin
                    period_d = cnt_q;
                    if (!in_tol_s) begin
                        match_d = '0;
                    end else if (match_inc_s == LOCK_C) begin
                        match_d  = match_inc_s;
                        locked_d = 1'b1;
                        state_d  = ST_LOCKED;
                    end else begin
                        match_d = match_inc_s;
                    end
                end else begin
                    lose_s = expire_s;
                end
            end
            ST_LOCKED: begin
                if (rise_s) begin
                    period_d = cnt_q;
                    if (in_tol_s) begin
                        state_d = ST_LOCKED;
                    end else begin
                        match_d  = '0;
                        locked_d = 1'b0;
                        state_d  = ST_TRACK;
                    end
                end else begin
                    lose_s = expire_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Loss of signal discards the measurement but keeps the last high time.
        if (lose_s) begin
            timeout_d      = 1'b1;
            period_d       = '0;
            period_valid_d = 1'b0;
            locked_d       = 1'b0;
            match_d        = '0;
            cnt_d          = '0;
            state_d        = ST_IDLE;
        end else begin
            timeout_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q         <= '0;
            fill_q         <= '0;
            s_d_q          <= 1'b0;
            cnt_q          <= '0;
            hcnt_q         <= '0;
            period_q       <= '0;
            high_time_q    <= '0;
            match_q        <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            tick_q         <= 1'b0;
            fall_tick_q    <= 1'b0;
            timeout_q      <= 1'b0;
            state_q        <= ST_IDLE;
        end else begin
            sync_q         <= sync_d;
            fill_q         <= fill_d;
            s_d_q          <= s_d_d;
            cnt_q          <= cnt_d;
            hcnt_q         <= hcnt_d;
            period_q       <= period_d;
            high_time_q    <= high_time_d;
            match_q        <= match_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            tick_q         <= tick_d;
            fall_tick_q    <= fall_tick_d;
            timeout_q      <= timeout_d;
            state_q        <= state_d;
        end
    end

    assign mon.tick         = tick_q;
    assign mon.fall_tick    = fall_tick_q;
    assign mon.period       = period_q;
    assign mon.high_time    = high_time_q;
    assign mon.period_valid = period_valid_q;
    assign mon.locked       = locked_q;
    assign mon.timeout      = timeout_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Directed bench for slow_clock_monitor: lock, mismatch, timeout, boundary rise,
// reset while locked, and random-phase latency.
module tb_slow_clock_monitor;

    localparam int CNT_W   = 28;
    localparam int TIMEOUT = 50;

    logic clock_in = 1'b0;
    logic reset_n  = 1'b0;

    slow_clock_monitor_if #(.CNT_W(CNT_W)) mon ();

    slow_clock_monitor #(
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .LOCK_COUNT  (4),
        .TOLERANCE   (2)
    ) dut (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .mon      (mon.slave)
    );

    always #5 clock_in = ~clock_in;

    int cyc      = 0;
    int tick_n   = 0;
    int fall_n   = 0;
    int to_n     = 0;
    int tick_cyc = 0;
    int to_cyc   = 0;
    int total    = 0;
    int bad      = 0;

    always @(posedge clock_in) cyc <= cyc + 1;

    // Event counters sampled on the inactive edge.
    always @(negedge clock_in) begin
        if (mon.tick) begin
            tick_n   <= tick_n + 1;
            tick_cyc <= cyc;
        end
        if (mon.fall_tick) begin
            fall_n <= fall_n + 1;
        end
        if (mon.timeout) begin
            to_n   <= to_n + 1;
            to_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic gen_cycle(input int hi, input int lo);
        mon.slow_in = 1'b1;
        repeat (hi) step();
        mon.slow_in = 1'b0;
        repeat (lo) step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (4) step();
    endtask

    int base_t;
    int base_f;
    int base_to;
    int c0;

    initial begin
        mon.slow_in = 1'b0;
        repeat (2) step();
        chk("rst_tick",      mon.tick, 0);
        chk("rst_fall_tick", mon.fall_tick, 0);
        chk("rst_period",    mon.period, 0);
        chk("rst_high_time", mon.high_time, 0);
        chk("rst_valid",     mon.period_valid, 0);
        chk("rst_locked",    mon.locked, 0);
        chk("rst_timeout",   mon.timeout, 0);
        reset_n = 1'b1;
        repeat (4) step();

        // Stable period 10, high 5
        base_t = tick_n;
        base_f = fall_n;
        gen_cycle(5, 5);
        chk("t1_arm_valid",  mon.period_valid, 0);
        chk("t1_arm_period", mon.period, 0);
        gen_cycle(5, 5);
        chk("t1_e2_valid",   mon.period_valid, 1);
        chk("t1_e2_period",  mon.period, 10);
        chk("t1_e2_locked",  mon.locked, 0);
        repeat (3) gen_cycle(5, 5);
        chk("t1_e5_locked",  mon.locked, 0);
        gen_cycle(5, 5);
        chk("t1_e6_locked",  mon.locked, 1);
        chk("t1_period",     mon.period, 10);
        chk("t1_high_time",  mon.high_time, 5);
        chk("t1_ticks",      tick_n - base_t, 6);
        chk("t1_falls",      fall_n - base_f, 6);

        // Periods 10,11,10,13 then 13s: match resets on the 13
        do_reset();
        gen_cycle(5, 5);
        gen_cycle(5, 6);
        gen_cycle(5, 5);
        gen_cycle(7, 6);
        gen_cycle(7, 6);
        gen_cycle(7, 6);
        chk("t2_e6_period",  mon.period, 13);
        gen_cycle(7, 6);
        chk("t2_e7_locked",  mon.locked, 0);
        gen_cycle(7, 6);
        chk("t2_e8_locked",  mon.locked, 0);
        gen_cycle(7, 6);
        chk("t2_e9_locked",  mon.locked, 1);
        chk("t2_high_time",  mon.high_time, 7);
        gen_cycle(5, 3);
        chk("t2_e10_locked", mon.locked, 1);
        chk("t2_e10_period", mon.period, 13);
        gen_cycle(5, 5);
        chk("t2_drop_locked", mon.locked, 0);
        chk("t2_drop_period", mon.period, 8);
        chk("t2_drop_valid",  mon.period_valid, 1);

        // Loss of signal
        base_to = to_n;
        repeat (60) step();
        chk("t3_timeout_cnt",   to_n - base_to, 1);
        chk("t3_timeout_delay", to_cyc - tick_cyc, TIMEOUT);
        chk("t3_period",        mon.period, 0);
        chk("t3_valid",         mon.period_valid, 0);
        chk("t3_locked",        mon.locked, 0);
        chk("t3_high_time",     mon.high_time, 5);
        base_t = tick_n;
        gen_cycle(5, 5);
        chk("t3_rearm_tick",   tick_n - base_t, 1);
        chk("t3_rearm_valid",  mon.period_valid, 0);
        chk("t3_rearm_period", mon.period, 0);
        gen_cycle(5, 45);
        chk("t3_meas_valid",   mon.period_valid, 1);
        chk("t3_meas_period",  mon.period, 10);

        // Rise lands on cnt == TIMEOUT
        base_to = to_n;
        gen_cycle(5, 5);
        chk("t4_period",     mon.period, TIMEOUT);
        chk("t4_no_timeout", to_n - base_to, 0);
        chk("t4_valid",      mon.period_valid, 1);

        // Reset mid-high while locked
        do_reset();
        repeat (6) gen_cycle(5, 5);
        chk("t5_locked", mon.locked, 1);
        mon.slow_in = 1'b1;
        repeat (4) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_period",    mon.period, 0);
        chk("t5_rst_high_time", mon.high_time, 0);
        chk("t5_rst_valid",     mon.period_valid, 0);
        chk("t5_rst_locked",    mon.locked, 0);
        chk("t5_rst_tick",      mon.tick, 0);
        repeat (2) step();
        base_t = tick_n;
        reset_n = 1'b1;
        repeat (8) step();
        chk("t5_no_tick_high", tick_n - base_t, 0);
        mon.slow_in = 1'b0;
        repeat (5) step();
        gen_cycle(5, 5);
        chk("t5_rise_tick",   tick_n - base_t, 1);
        chk("t5_rise_valid",  mon.period_valid, 0);
        chk("t5_rise_period", mon.period, 0);

        // Random-phase input edges
        base_t = tick_n;
        for (int i = 0; i < 8; i++) begin
            #($urandom_range(1, 8));
            c0 = cyc;
            mon.slow_in = 1'b1;
            repeat (6) @(posedge clock_in);
            #($urandom_range(1, 8));
            mon.slow_in = 1'b0;
            repeat (6) @(posedge clock_in);
            #1;
            chk("t6_latency", tick_cyc - c0, 3);
        end
        chk("t6_tick_count", tick_n - base_t, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
